// File: rtl/ace_ar_region_demux.sv
// ace_ar_region_demux: routes ACE reads to one of NumMst ports by address window,
// keeping every in-flight read on a single target and answering unmapped reads with DECERR.
package culsans_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [3:0]  snoop;
        logic [1:0]  bar;
        logic [1:0]  domain;
    } ace_ar_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [3:0]  resp;
        logic        last;
    } ace_r_t;
endpackage

module ace_ar_region_demux #(
    parameter int unsigned NumMst = 2,
    parameter int unsigned NumRules = 3,
    parameter int unsigned MaxTxns = 8,
    parameter int unsigned AddrWidth = 64,
    parameter logic [AddrWidth-1:0] RuleBase [NumRules] = '{64'h8000_0000, 64'h1000_0000, 64'h0},
    parameter logic [AddrWidth-1:0] RuleLength [NumRules] = '{64'h4000_0000, 64'h1000, 64'h1000},
    parameter int unsigned RuleTarget [NumRules] = '{0, 1, 1},
    parameter type ar_chan_t = culsans_pkg::ace_ar_t,
    parameter type r_chan_t = culsans_pkg::ace_r_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  ar_chan_t                slv_ar_i,
    input  logic                    slv_ar_valid_i,
    output logic                    slv_ar_ready_o,
    output r_chan_t                 slv_r_o,
    output logic                    slv_r_valid_o,
    input  logic                    slv_r_ready_i,
    output ar_chan_t [NumMst-1:0]   mst_ar_o,
    output logic [NumMst-1:0]       mst_ar_valid_o,
    input  logic [NumMst-1:0]       mst_ar_ready_i,
    input  r_chan_t [NumMst-1:0]    mst_r_i,
    input  logic [NumMst-1:0]       mst_r_valid_i,
    output logic [NumMst-1:0]       mst_r_ready_o,
    output logic                    busy_o,
    output logic                    dec_err_o
);
    localparam int unsigned TgtW = NumMst > 1 ? $clog2(NumMst) : 1;
    localparam int unsigned CntW = $clog2(MaxTxns + 1);

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state, state_next;
    logic [CntW-1:0] cnt;
    logic [TgtW-1:0] cur_tgt, dec_tgt;
    logic            dec_hit, oreg_valid, ar_acc, r_last_hs, err_last;
    logic [AddrWidth:0] addr_x;
    ar_chan_t        oreg, err_ar;
    logic [$bits(err_ar.len)-1:0] beat;

    // Descending scan so the lowest matching rule index wins; one extra bit keeps base+length from wrapping.
    always_comb begin
        dec_hit = 1'b0;
        dec_tgt = '0;
        addr_x = {1'b0, slv_ar_i.addr[AddrWidth-1:0]};
        for (int i = int'(NumRules) - 1; i >= 0; i--) begin
            if (addr_x >= {1'b0, RuleBase[i]} && addr_x < {1'b0, RuleBase[i]} + {1'b0, RuleLength[i]}) begin
                dec_hit = 1'b1;
                dec_tgt = TgtW'(RuleTarget[i]);
            end
        end
    end

    assign slv_ar_ready_o = rst_ni && state == IDLE && cnt < CntW'(MaxTxns)
                          && (cnt == '0 || (dec_hit && dec_tgt == cur_tgt))
                          && (!oreg_valid || mst_ar_ready_i[cur_tgt]);
    assign ar_acc = slv_ar_valid_i && slv_ar_ready_o;
    assign dec_err_o = ar_acc && !dec_hit;
    assign err_last = beat == err_ar.len;
    assign r_last_hs = state == RESP ? slv_r_ready_i && err_last
                                     : mst_r_valid_i[cur_tgt] && slv_r_ready_i && mst_r_i[cur_tgt].last;
    assign busy_o = cnt != '0 || oreg_valid || state != IDLE;
    assign mst_ar_o = {NumMst{oreg}};

    // Downstream R beats are held off while the error responder owns the upstream R channel.
    always_comb begin
        mst_ar_valid_o = '0;
        mst_r_ready_o = '0;
        mst_ar_valid_o[cur_tgt] = oreg_valid;
        mst_r_ready_o[cur_tgt] = rst_ni && state == IDLE && slv_r_ready_i;
        slv_r_o = mst_r_i[cur_tgt];
        slv_r_valid_o = rst_ni && state == IDLE && mst_r_valid_i[cur_tgt];
        if (state == RESP) begin
            slv_r_o = '0;
            slv_r_o.id = err_ar.id;
            slv_r_o.resp = 4'b0011;
            slv_r_o.last = err_last;
            slv_r_valid_o = 1'b1;
        end
    end

    always_comb state_next = state == IDLE ? (dec_err_o ? RESP : IDLE)
                                           : (slv_r_ready_i && err_last ? IDLE : RESP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            cur_tgt <= '0;
            oreg_valid <= 1'b0;
            oreg <= '0;
            err_ar <= '0;
            beat <= '0;
        end else begin
            cnt <= cnt + CntW'(ar_acc) - CntW'(r_last_hs && cnt != '0);
            if (ar_acc && dec_hit) begin
                cur_tgt <= dec_tgt;
                oreg <= slv_ar_i;
                oreg_valid <= 1'b1;
            end else if (mst_ar_ready_i[cur_tgt]) begin
                oreg_valid <= 1'b0;
            end
            if (dec_err_o) err_ar <= slv_ar_i;
            beat <= state == RESP ? (slv_r_ready_i ? (err_last ? '0 : beat + 1'b1) : beat) : '0;
        end
    end
endmodule

// File: tb/tb_ace_ar_region_demux.sv
// tb_ace_ar_region_demux: scoreboard bench; expected AR forwards and R beats are queued
// when stimulus is driven and popped by a negedge monitor as the DUT hands them over.
module tb_ace_ar_region_demux;
    typedef culsans_pkg::ace_ar_t ar_t;
    typedef culsans_pkg::ace_r_t r_t;
    typedef struct {
        int  port;
        ar_t ar;
    } ear_t;

    logic clk = 1'b0, rst_n;
    ar_t slv_ar;
    logic slv_ar_valid, slv_ar_ready, slv_r_valid, slv_r_ready, busy, dec_err;
    r_t slv_r;
    ar_t [1:0] mst_ar;
    logic [1:0] mst_ar_valid, mst_ar_ready, mst_r_valid, mst_r_ready;
    r_t [1:0] mst_r;

    int total = 0, bad = 0;
    ear_t exp_ar[$];
    r_t exp_r[$];
    ear_t ea_m;
    r_t er_m;

    always #5 clk = ~clk;

    ace_ar_region_demux dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_ar_i(slv_ar), .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready),
        .slv_r_o(slv_r), .slv_r_valid_o(slv_r_valid), .slv_r_ready_i(slv_r_ready),
        .mst_ar_o(mst_ar), .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready),
        .mst_r_i(mst_r), .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(mst_r_ready),
        .busy_o(busy), .dec_err_o(dec_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int exp_port(input logic [63:0] a);
        if (a >= 64'h8000_0000 && a < 64'hC000_0000) return 0;
        if (a >= 64'h1000_0000 && a < 64'h1000_1000) return 1;
        if (a < 64'h1000) return 1;
        return 2;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (mst_ar_valid != '0) check("ar_onehot", 128'($countones(mst_ar_valid)), 128'(1));
            for (int p = 0; p < 2; p++) begin
                if (mst_ar_valid[p] && mst_ar_ready[p]) begin
                    if (exp_ar.size() == 0) check("ar_unexp", 128'(p), 128'(99));
                    else begin
                        ea_m = exp_ar.pop_front();
                        check("ar_port", 128'(p), 128'(ea_m.port));
                        check("ar_payload", 128'(mst_ar[p]), 128'(ea_m.ar));
                    end
                end
            end
            if (slv_r_valid && slv_r_ready) begin
                if (exp_r.size() == 0) check("r_unexp", 128'(slv_r), 128'(0));
                else begin
                    er_m = exp_r.pop_front();
                    check("r_beat", 128'(slv_r), 128'(er_m));
                end
            end
        end
    end

    // Starts and ends at posedge+1; stall = negedges that must show ready low first.
    task automatic ar_send(input logic [63:0] a, input logic [3:0] id, input logic [7:0] len, input int stall);
        ar_t x;
        r_t e;
        ear_t ea;
        int port;
        bit ok;
        ok = 1'b0;
        x = '0;
        x.addr = a; x.id = id; x.len = len; x.size = 3'd3; x.burst = 2'b01;
        x.cache = 4'b0011; x.snoop = 4'b0001; x.domain = 2'b10;
        port = exp_port(a);
        slv_ar = x;
        slv_ar_valid = 1'b1;
        if (port == 2) begin
            for (int b = 0; b <= int'(len); b++) begin
                e = '0; e.id = id; e.resp = 4'b0011; e.last = (b == int'(len));
                exp_r.push_back(e);
            end
        end else begin
            ea.port = port; ea.ar = x;
            exp_ar.push_back(ea);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("ar_stall", 128'(slv_ar_ready), 128'(0));
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (slv_ar_ready) begin ok = 1'b1; break; end
        end
        check("ar_accept", 128'(ok), 128'(1));
        check("dec_err", 128'(dec_err), 128'(ok && port == 2));
        @(posedge clk); #1 slv_ar_valid = 1'b0;
        @(negedge clk);
        check("ar_lat", 128'(mst_ar_valid), port == 2 ? 128'(0) : 128'(2'b01 << port));
        check("dec_err_pulse", 128'(dec_err), 128'(0));
        @(posedge clk); #1;
    endtask

    task automatic r_beat(input int p, input logic [3:0] id, input logic [63:0] d, input logic last);
        r_t b;
        bit ok;
        ok = 1'b0;
        b = '0; b.id = id; b.data = d; b.resp = 4'b0100; b.last = last;
        mst_r[p] = b;
        mst_r_valid[p] = 1'b1;
        exp_r.push_back(b);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mst_r_ready[p] && slv_r_ready) begin ok = 1'b1; break; end
        end
        check("r_ready", 128'(ok), 128'(1));
        check("r_ready_other", 128'(mst_r_ready[1-p]), 128'(0));
        @(posedge clk); #1 mst_r_valid[p] = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ar_ready"}, 128'(slv_ar_ready), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_dec_err"}, 128'(dec_err), 128'(0));
        check({tag, "_ar_valid"}, 128'(mst_ar_valid), 128'(0));
        check({tag, "_r_ready"}, 128'(mst_r_ready), 128'(0));
        check({tag, "_r_valid"}, 128'(slv_r_valid), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; slv_ar = '0; slv_ar_valid = 1'b0; slv_r_ready = 1'b1;
        mst_ar_ready = 2'b11; mst_r = '0; mst_r_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1 check_quiet("rst");
        mst_r_valid = 2'b00;
        @(negedge clk) rst_n = 1'b1;
        #1 check("post_rst_ready", 128'(slv_ar_ready), 128'(1));
        @(posedge clk); #1;

        // Basic forward with backpressure, then accept and last beat in one cycle.
        mst_ar_ready = 2'b00;
        ar_send(64'h8000_1000, 4'd3, 8'd0, 0);
        repeat (3) begin
            @(negedge clk);
            check("ar_hold_v", 128'(mst_ar_valid), 128'(1));
            check("ar_hold_addr", 128'(mst_ar[0].addr), 128'(64'h8000_1000));
            check("ar_hold_id", 128'(mst_ar[0].id), 128'(3));
        end
        @(posedge clk); #1 mst_ar_ready = 2'b11;
        check("busy_1", 128'(busy), 128'(1));
        fork
            ar_send(64'h8000_2000, 4'd4, 8'd1, 0);
            r_beat(0, 4'd3, 64'hDEAD_BEEF_0123_4567, 1'b1);
        join
        check("busy_same_cycle", 128'(busy), 128'(1));
        r_beat(0, 4'd4, 64'h55, 1'b0);
        r_beat(0, 4'd4, 64'h66, 1'b1);
        @(negedge clk) check("busy_idle_a", 128'(busy), 128'(0));
        @(posedge clk); #1;

        // Target switch waits for the other port to drain.
        ar_send(64'h1000_0000, 4'd1, 8'd0, 0);
        fork
            ar_send(64'h8000_0000, 4'd2, 8'd0, 3);
            begin repeat (3) @(posedge clk); #1; r_beat(1, 4'd1, 64'h1111, 1'b1); end
        join
        r_beat(0, 4'd2, 64'h2222, 1'b1);
        @(negedge clk) check("busy_idle_b", 128'(busy), 128'(0));
        @(posedge clk); #1;

        // Outstanding limit.
        for (int i = 0; i < 8; i++) ar_send(64'h8000_0000 + 64'(i * 64), 4'(i), 8'd0, 0);
        fork
            ar_send(64'h8000_4000, 4'd8, 8'd0, 4);
            begin repeat (4) @(posedge clk); #1; r_beat(0, 4'd0, 64'h0, 1'b1); end
        join
        fork
            ar_send(64'h8000_5000, 4'd9, 8'd0, 3);
            begin repeat (3) @(posedge clk); #1; r_beat(0, 4'd1, 64'h1, 1'b1); end
        join
        for (int i = 2; i < 10; i++) begin
            if (i == 9) check("busy_last_one", 128'(busy), 128'(1));
            r_beat(0, 4'(i), 64'(i), 1'b1);
        end
        @(negedge clk) check("busy_idle_c", 128'(busy), 128'(0));
        @(posedge clk); #1;

        // Unmapped read answered with DECERR beats, held off by upstream ready.
        slv_r_ready = 1'b0;
        ar_send(64'h5000_0000, 4'd5, 8'd3, 0);
        check("err_ar_ready", 128'(slv_ar_ready), 128'(0));
        check("err_busy", 128'(busy), 128'(1));
        check("err_r_valid", 128'(slv_r_valid), 128'(1));
        check("err_mst_r_ready", 128'(mst_r_ready), 128'(0));
        repeat (2) @(posedge clk);
        #1 slv_r_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("err_done_busy", 128'(busy), 128'(0));
        check("err_beats_left", 128'(exp_r.size()), 128'(0));

        // Asynchronous reset with reads outstanding and a stalled forward.
        for (int i = 0; i < 3; i++) ar_send(64'h8000_0000 + 64'(i * 256), 4'(i), 8'd0, 0);
        mst_ar_ready = 2'b00;
        ar_send(64'h8000_0400, 4'd3, 8'd0, 0);
        #3 rst_n = 1'b0;
        #1 check_quiet("rst_cnt");
        exp_ar.delete(); exp_r.delete();
        mst_ar_ready = 2'b11;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an error response.
        slv_r_ready = 1'b0;
        ar_send(64'h5000_0000, 4'd2, 8'd7, 0);
        check("resp_before_rst", 128'(slv_r_valid), 128'(1));
        #3 rst_n = 1'b0;
        #1 check_quiet("rst_resp");
        exp_ar.delete(); exp_r.delete();
        slv_r_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        ar_send(64'h0000_0800, 4'd7, 8'd0, 0);
        r_beat(1, 4'd7, 64'h7777, 1'b1);
        @(negedge clk) check("busy_idle_d", 128'(busy), 128'(0));
        repeat (3) @(posedge clk);
        #1 check("ar_queue_empty", 128'(exp_ar.size()), 128'(0));
        check("r_queue_empty", 128'(exp_r.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
